// File: rtl/tile_rom_responder_if.sv
// rtl/tile_rom_responder_if.sv - tile-ROM fetch and SDRAM read port bundle
interface tile_rom_responder_if #(
    parameter int ADDR_W = 18,
    parameter int SDR_AW = 24
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              rom_valid;
    logic              sdr_req;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_ack;
    logic [15:0]       sdr_data;

    // master: tile cache plus SDRAM controller; slave: the responder
    modport master (
        output rom_req, rom_addr, sdr_ack, sdr_data,
        input  rom_data, rom_valid, sdr_req, sdr_addr
    );

    modport slave (
        input  rom_req, rom_addr, sdr_ack, sdr_data,
        output rom_data, rom_valid, sdr_req, sdr_addr
    );
endinterface

// File: rtl/tile_rom_responder.sv
// rtl/tile_rom_responder.sv - 32-bit tile-ROM fetch served as two 16-bit SDRAM reads
module tile_rom_responder #(
    parameter int                ADDR_W = 18,
    parameter int                SDR_AW = 24,
    parameter logic [SDR_AW-1:0] BASE   = SDR_AW'(24'h000000)
) (
    input  logic clk,
    input  logic reset,
    tile_rom_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] lat_addr, lat_addr_next;
    logic              last_ok, last_ok_next;
    logic              abort, abort_next;
    logic              valid_next;
    logic [31:0]       data_next;
    logic              sdr_req_c;
    logic [SDR_AW-1:0] sdr_addr_c;
    logic [SDR_AW-1:0] even_word, odd_word;
    logic              addr_match;

    assign addr_match = (bus.rom_addr == lat_addr);
    assign even_word  = BASE + SDR_AW'({lat_addr, 1'b0});
    assign odd_word   = even_word + SDR_AW'(1);

    always_comb begin
        state_next    = state;
        lat_addr_next = lat_addr;
        last_ok_next  = last_ok;
        abort_next    = abort;
        valid_next    = 1'b0;
        data_next     = bus.rom_data;
        sdr_req_c     = 1'b0;
        sdr_addr_c    = '0;

        // Requester walked away mid-fetch; the SDRAM reads still run to completion
        if ((state == LO || state == GAP || state == HI) && (!bus.rom_req || !addr_match))
            abort_next = 1'b1;

        case (state)
            IDLE: begin
                if (bus.rom_req) begin
                    if (!last_ok || !addr_match) begin
                        lat_addr_next = bus.rom_addr;
                        last_ok_next  = 1'b0;
                        abort_next    = 1'b0;
                        state_next    = LO;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            LO: begin
                sdr_req_c  = 1'b1;
                sdr_addr_c = even_word;
                if (bus.sdr_ack) begin
                    data_next[31:16] = bus.sdr_data;
                    state_next       = GAP;
                end
            end
            GAP: begin
                state_next = HI;
            end
            HI: begin
                sdr_req_c  = 1'b1;
                sdr_addr_c = odd_word;
                if (bus.sdr_ack) begin
                    data_next[15:0] = bus.sdr_data;
                    last_ok_next    = 1'b1;
                    valid_next      = !abort && bus.rom_req && addr_match;
                    state_next      = abort ? IDLE : DONE;
                end
            end
            DONE: begin
                valid_next = bus.rom_req && addr_match;
                if (!bus.rom_req || !addr_match)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_addr      <= '0;
            last_ok       <= 1'b0;
            abort         <= 1'b0;
            bus.rom_valid <= 1'b0;
            bus.rom_data  <= '0;
        end else begin
            state         <= state_next;
            lat_addr      <= lat_addr_next;
            last_ok       <= last_ok_next;
            abort         <= abort_next;
            bus.rom_valid <= valid_next;
            bus.rom_data  <= data_next;
        end
    end

    assign bus.sdr_req  = sdr_req_c;
    assign bus.sdr_addr = sdr_addr_c;
endmodule

// File: doc/tile_rom_responder.md
# tile_rom_responder

Responder end of the tile-cache ROM fetch protocol (`rom_req` / `rom_addr` / `rom_data` / `rom_valid`). It sits between a tile cache and the SDRAM controller port. Each 32-bit tile-ROM request becomes two sequential 16-bit SDRAM word reads. The block holds the assembled 32-bit result and a valid flag for as long as the requester keeps the request asserted.

## Interface
Parameters
- `ADDR_W`, default 18: width of `rom_addr` (32-bit word address).
- `SDR_AW`, default 24: width of `sdr_addr` (16-bit word address).
- `BASE`, default 24'h000000: 16-bit word offset of the tile ROM region in SDRAM.

Ports
- `clk`: input, 1. Clock.
- `reset`: input, 1. Reset, synchronous, active-high.
- `rom_req`: input, 1. Level request; held high by the requester until it no longer needs the data.
- `rom_addr`: input, ADDR_W. 32-bit word address; stable while `rom_req` is high, except when the requester retargets.
- `rom_data`: output, 32. Fetched data; valid while `rom_valid` is high.
- `rom_valid`: output, 1. Registered; data ready for the currently presented `rom_addr`.
- `sdr_req`: output, 1. Level request to the SDRAM controller.
- `sdr_addr`: output, SDR_AW. 16-bit word address for SDRAM.
- `sdr_ack`: input, 1. One-cycle pulse; `sdr_data` is valid in the same cycle.
- `sdr_data`: input, 16. SDRAM read data.

## Operation
- Address mapping:
  - even word = `BASE + {rom_addr, 1'b0}`; odd word = even + 1.
  - Sums are truncated to SDR_AW and wrap modulo 2^SDR_AW.
- Data packing: even word goes to `rom_data[31:16]`, odd word to `rom_data[15:0]` (big-endian).
- Internal registers:
  - `lat_addr` (ADDR_W): address being or last fetched.
  - `last_ok`: `lat_addr` and `rom_data` hold a completed fetch.
  - `abort`: the requester dropped or changed the request mid-fetch.
- States:
  - IDLE
    - `rom_req` high and (`last_ok` == 0 or `rom_addr` != `lat_addr`): latch `lat_addr`, clear `last_ok` and `abort`, go to LO.
    - `rom_req` high and `last_ok` and `rom_addr` == `lat_addr`: go to DONE (reuse, no SDRAM access).
  - LO: `sdr_req` = 1, `sdr_addr` = even word. On `sdr_ack`: capture `rom_data[31:16]`, go to GAP.
  - GAP: `sdr_req` = 0 for exactly one cycle, then go to HI.
  - HI: `sdr_req` = 1, `sdr_addr` = odd word. On `sdr_ack`: capture `rom_data[15:0]`, set `last_ok` = 1.
    - If `abort` is clear, go to DONE.
    - If `abort` is set, go to IDLE.
  - DONE: `rom_valid` is high while `rom_req` is high and `rom_addr` == `lat_addr`.
    - `rom_req` low: go to IDLE.
    - `rom_addr` != `lat_addr` with `rom_req` high: go to IDLE, which restarts the fetch on the next cycle.
- Abort:
  - In LO/GAP/HI, `rom_req` low or `rom_addr` != `lat_addr` sets `abort`.
  - The SDRAM transaction in progress is never cancelled: both halves always complete.
  - `rom_valid` is never asserted for an aborted fetch.
  - An aborted fetch still sets `last_ok`, so a later request to the same address is served by reuse.
- `sdr_addr` is driven from `lat_addr` only, never combinationally from `rom_addr`.
- `sdr_ack` seen in IDLE/GAP/DONE is ignored.

## Timing
- Reset values: `rom_valid` = 0, `rom_data` = 0, `sdr_req` = 0, `sdr_addr` = 0, state = IDLE, `last_ok` = 0, `abort` = 0.
- Reset mid-fetch: `sdr_req` drops on the next cycle. The SDRAM controller tolerates a dropped request.
- Fresh fetch:
  - `rom_req` sampled high in IDLE at cycle 0; `sdr_req` high from cycle 1.
  - First `sdr_ack` at cycle a; `sdr_req` low at a+1; `sdr_req` high with the odd word at a+2.
  - Second `sdr_ack` at cycle b; `rom_valid` = 1 and `rom_data` complete at b+1.
- Reuse hit: `rom_valid` = 1 at cycle 2 after `rom_req` is sampled at cycle 0 (IDLE then DONE).
- `rom_valid` falls in the cycle after `rom_req` falls or `rom_addr` changes, since it is registered.
- `rom_data` is held stable from `rom_valid` rise until the next fetch starts capturing.
- Back-to-back requests: minimum `rom_req`-low time is 1 cycle. A new request is accepted in the first IDLE cycle.

## Test plan
- Fresh fetch, BASE = 0:
  - `rom_addr` = 18'h00005; acks return 16'hAAAA then 16'h5555.
  - Required: `sdr_addr` = 24'h00000A then 24'h00000B, one-cycle `sdr_req` gap, `rom_data` = 32'hAAAA5555, `rom_valid` one cycle after the second ack.
- BASE = 24'h100000 with `rom_addr` = 18'h3FFFF: `sdr_addr` = 24'h17FFFE then 24'h17FFFF.
- Reuse:
  - Repeat the request to 18'h00005 after `rom_req` has been low 1 cycle.
  - Required: no `sdr_req`; `rom_valid` at cycle 2 with 32'hAAAA5555.
- Abort:
  - Drop `rom_req` after the first ack.
  - Required: the second read still issues, `rom_valid` stays 0, and a subsequent request to the same address reuses without SDRAM access.
- Retarget in DONE:
  - Change `rom_addr` from 18'h00005 to 18'h00010 with `rom_req` held high.
  - Required: `rom_valid` drops next cycle and a new fetch issues at `sdr_addr` 24'h000020.
- Reset during HI:
  - Required: all outputs 0 next cycle, and the next request to the same address performs a full SDRAM fetch.
